// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table.
// Counter encoding: 0 strong not-taken .. 3 strong taken; bit 1 is the direction.
package bht_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t STRONG_NT = 2'd0;
  localparam cnt_t WEAK_NT   = 2'd1;
  localparam cnt_t WEAK_T    = 2'd2;
  localparam cnt_t STRONG_T  = 2'd3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bht_cnt_next.sv
// Saturating 2-bit counter step: moves one step toward the resolved direction
// and sticks at the ends instead of wrapping.
module bht_cnt_next
  import bht_pkg::*;
(
  input  cnt_t cur,
  input  logic taken,
  output cnt_t next
);

  // Step up on taken, down on not-taken, holding at STRONG_T / STRONG_NT.
  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != STRONG_T) next = cur + 2'd1;
    end else begin
      if (cur != STRONG_NT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: 2**IDX_W saturating counters indexed by PC.
// Predict port (fetch) has one cycle of latency; update port (execute) trains
// the addressed counter. After reset the table walks through every entry
// writing INIT_CNT before it reports ready.
// Optional macro GSHARE_EN: XORs a global history register into the index.
module branch_history_table
  import bht_pkg::*;
#(
  parameter int   IDX_W    = 4,
  parameter int   PC_W     = 32,
  parameter cnt_t INIT_CNT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            pred_req,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [1:0]      pred_count,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             ready_q, ready_d;
  logic             pred_valid_q, pred_valid_d;
  cnt_t             pred_count_q, pred_count_d;
  cnt_t             table_q [ENTRIES];
  cnt_t             table_d [ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  cnt_t             upd_next;

  // PC bits below the word offset and above the index never address the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                            upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // Both ports hash with the history as it stood before this cycle's shift.
  always_comb begin
    pred_idx = pred_pc[IDX_W+1:2] ^ ghr_q;
    upd_idx  = upd_pc[IDX_W+1:2] ^ ghr_q;
  end

  // History shifts in each resolved direction, but only once the table is live.
  always_comb begin
    ghr_d = ghr_q;
    if (state_q == RUN && upd_en) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
  end

  // Global history register, cleared with the rest of the control state.
  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  // Plain PC-indexed table: word-aligned PC bits select the entry.
  always_comb begin
    pred_idx = pred_pc[IDX_W+1:2];
    upd_idx  = upd_pc[IDX_W+1:2];
  end
`endif

  bht_cnt_next u_cnt_next (
    .cur   (table_q[upd_idx]),
    .taken (upd_taken),
    .next  (upd_next)
  );

  // Init sweep, prediction read and update write; predictions read the old
  // table contents so a same-cycle update is only seen by later requests.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    ready_d      = ready_q;
    pred_valid_d = 1'b0;
    pred_count_d = pred_count_q;
    table_d      = table_q;
    case (state_q)
      INIT: begin
        table_d[init_idx_q] = INIT_CNT;
        init_idx_d          = init_idx_q + IDX_W'(1);
        if (init_idx_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (pred_req) begin
          pred_valid_d = 1'b1;
          pred_count_d = table_q[pred_idx];
        end
        if (upd_en) table_d[upd_idx] = upd_next;
      end
      default: state_d = INIT;
    endcase
  end

  // Control and output registers; reset restarts the init sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      init_idx_q   <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_count_q <= STRONG_NT;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      ready_q      <= ready_d;
      pred_valid_q <= pred_valid_d;
      pred_count_q <= pred_count_d;
    end
  end

  // Counter storage needs no reset: the init sweep overwrites every entry.
  always_ff @(posedge clk) begin
    if (!rst) table_q <= table_d;
  end

  assign ready      = ready_q;
  assign pred_valid = pred_valid_q;
  assign pred_count = pred_count_q;
  assign pred_taken = pred_count_q[1];

endmodule
